// File: rtl/ika_eg_rate_timer_if.sv
// Slot channel of the envelope rate timer: one effective rate in,
// one step decision out, two enable cycles later.
interface ika_eg_rate_timer_if;
  logic       i_RATE_VALID;
  logic [5:0] i_RATE;
  logic       o_STEP_VALID;
  logic       o_STEP_EN;
  logic [4:0] o_STEP_SIZE;

  // Rate source / step consumer side
  modport master (
    output i_RATE_VALID, i_RATE,
    input  o_STEP_VALID, o_STEP_EN, o_STEP_SIZE
  );

  // Timer side
  modport slave (
    input  i_RATE_VALID, i_RATE,
    output o_STEP_VALID, o_STEP_EN, o_STEP_SIZE
  );
endinterface

// File: rtl/ika_eg_rate_timer.sv
// Envelope attenuation-rate timer: divides the sample strobe, advances a
// global time counter, derives attenuation rate and envelope phase, and
// turns serially presented slot rates into step enables and step sizes.
module ika_eg_rate_timer #(
  parameter int unsigned CNTW = 15,
  parameter int unsigned DIV  = 3,
  parameter int unsigned AW   = $clog2(CNTW + 1)
) (
  input  logic            i_EMUCLK,
  input  logic            i_MRST,
  input  logic            i_phi1_NCEN_n,
  input  logic            i_SAMPLE_STB,
  input  logic            i_TEST_TICK,
  output logic            o_TICK,
  output logic [CNTW-1:0] o_CNTR,
  output logic [AW-1:0]   o_ATTEN_RATE,
  output logic [2:0]      o_ENV_CNTR,
  ika_eg_rate_timer_if.slave slot
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW = ((AW > 4) ? AW : 4) + 1;

  function automatic logic [AW-1:0] ctz(input logic [CNTW-1:0] v);
    logic [AW-1:0] r;
    r = AW'(CNTW);
    for (int unsigned i = 0; i < CNTW; i++)
      if (v[CNTW-1-i]) r = AW'(CNTW - 1 - i);
    return r;
  endfunction

  logic            en;
  logic            tick;
  logic [DW-1:0]   div_q, div_d;
  logic            tick_q;
  logic [CNTW-1:0] cntr_q, cntr_d;
  logic [AW-1:0]   ar_q, ar_d;
  logic [2:0]      env_q, env_d;
  logic [CNTW+2:0] env_ext;

  logic            s1_vld_q;
  logic [5:0]      s1_rate_q;
  logic [AW-1:0]   s1_ar_q;
  logic [2:0]      s1_ph_q;

  logic [3:0]      hi;
  logic [1:0]      lo;
  logic            ph_lt;
  logic [SW-1:0]   sum;
  logic            step_vld_d, step_en_d;
  logic [4:0]      step_size_d;
  logic            step_vld_q, step_en_q;
  logic [4:0]      step_size_q;

  assign en = ~i_phi1_NCEN_n;

  // Divider, tick decision and the post-tick counter/rate/phase values
  always_comb begin
    tick  = i_SAMPLE_STB && (i_TEST_TICK || (div_q == DW'(DIV - 1)));
    div_d = div_q;
    if (i_SAMPLE_STB) div_d = tick ? '0 : div_q + 1'b1;
    cntr_d  = cntr_q + 1'b1;
    ar_d    = ctz(cntr_d);
    // Widened so a shift past the counter top reads zeros
    env_ext = {3'b000, cntr_d} >> ({1'b0, ar_d} + 1'b1);
    env_d   = env_ext[2:0];
  end

  // Timer state: advances only on enable cycles
  always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
    if (i_MRST) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      cntr_q <= '0;
      ar_q   <= '0;
      env_q  <= '0;
    end else if (en) begin
      div_q  <= div_d;
      tick_q <= tick;
      if (tick) begin
        cntr_q <= cntr_d;
        ar_q   <= ar_d;
        env_q  <= env_d;
      end
    end
  end

  // Stage 1: capture slot rate with the pre-tick rate and phase
  always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
    if (i_MRST) begin
      s1_vld_q  <= 1'b0;
      s1_rate_q <= '0;
      s1_ar_q   <= '0;
      s1_ph_q   <= '0;
    end else if (en) begin
      s1_vld_q  <= slot.i_RATE_VALID;
      s1_rate_q <= slot.i_RATE;
      s1_ar_q   <= ar_q;
      s1_ph_q   <= env_q;
    end
  end

  // Step rule evaluation on the captured slot
  always_comb begin
    hi          = s1_rate_q[5:2];
    lo          = s1_rate_q[1:0];
    ph_lt       = {1'b0, s1_ph_q} < (4'd4 + {2'b00, lo});
    sum         = SW'(s1_ar_q) + SW'(hi);
    step_vld_d  = s1_vld_q;
    step_en_d   = 1'b0;
    step_size_d = '0;
    if (s1_vld_q && (s1_rate_q != 6'd0)) begin
      if (hi >= 4'd12) begin
        // hi-12 equals hi[1:0] for hi in 12..15
        step_en_d   = 1'b1;
        step_size_d = ph_lt ? (5'd2 << hi[1:0]) : (5'd1 << hi[1:0]);
      end else begin
        step_en_d   = (sum >= SW'(11)) && ph_lt;
        step_size_d = {4'b0000, step_en_d};
      end
    end
  end

  // Stage 2: registered step result
  always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
    if (i_MRST) begin
      step_vld_q  <= 1'b0;
      step_en_q   <= 1'b0;
      step_size_q <= '0;
    end else if (en) begin
      step_vld_q  <= step_vld_d;
      step_en_q   <= step_en_d;
      step_size_q <= step_size_d;
    end
  end

  assign o_TICK            = tick_q;
  assign o_CNTR            = cntr_q;
  assign o_ATTEN_RATE      = ar_q;
  assign o_ENV_CNTR        = env_q;
  assign slot.o_STEP_VALID = step_vld_q;
  assign slot.o_STEP_EN    = step_en_q;
  assign slot.o_STEP_SIZE  = step_size_q;

endmodule

// File: tb/tb_ika_eg_rate_timer.sv
// Directed bench for ika_eg_rate_timer (CNTW=15, DIV=3) with
// hand-computed expectations.
module tb_ika_eg_rate_timer;
  logic        clk = 1'b0;
  logic        rst, ncen, stb, tt;
  logic        tick;
  logic [14:0] cntr;
  logic [3:0]  ar;
  logic [2:0]  env;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  ika_eg_rate_timer_if slot ();

  ika_eg_rate_timer #(.CNTW(15), .DIV(3)) dut (
    .i_EMUCLK      (clk),
    .i_MRST        (rst),
    .i_phi1_NCEN_n (ncen),
    .i_SAMPLE_STB  (stb),
    .i_TEST_TICK   (tt),
    .o_TICK        (tick),
    .o_CNTR        (cntr),
    .o_ATTEN_RATE  (ar),
    .o_ENV_CNTR    (env),
    .slot          (slot.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_timer(input string tag, input logic t, input int c, input int a, input int e);
    chk({tag, ".tick"}, 32'(tick), 32'(t));
    chk({tag, ".cntr"}, 32'(cntr), 32'(c));
    chk({tag, ".atten"}, 32'(ar), 32'(a));
    chk({tag, ".env"}, 32'(env), 32'(e));
  endtask

  task automatic chk_step(input string tag, input logic v, input logic e, input int s);
    chk({tag, ".valid"}, 32'(slot.o_STEP_VALID), 32'(v));
    chk({tag, ".en"}, 32'(slot.o_STEP_EN), 32'(e));
    chk({tag, ".size"}, 32'(slot.o_STEP_SIZE), 32'(s));
  endtask

  task automatic strobe(input logic test);
    stb = 1'b1; tt = test;
    cyc();
    stb = 1'b0; tt = 1'b0;
  endtask

  // One slot in, result checked two enable edges later
  task automatic send(input string tag, input logic [5:0] rate, input logic e, input int s);
    slot.i_RATE_VALID = 1'b1; slot.i_RATE = rate;
    cyc();
    slot.i_RATE_VALID = 1'b0; slot.i_RATE = '0;
    cyc();
    chk_step(tag, 1'b1, e, s);
  endtask

  initial begin
    rst = 1'b1; ncen = 1'b0; stb = 1'b0; tt = 1'b0;
    slot.i_RATE_VALID = 1'b0; slot.i_RATE = '0;
    #12;
    chk_timer("rst", 0, 0, 0, 0);
    chk_step("rst", 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    cyc();

    // Divider by 3
    strobe(0); chk("stb1.tick", 32'(tick), 0);
    strobe(0); chk("stb2.tick", 32'(tick), 0);
    strobe(0); chk_timer("stb3", 1, 1, 0, 0);
    cyc();     chk("pulse.end", 32'(tick), 0);

    // Test ticks must clear a part-counted divider
    strobe(0); chk("stb4.tick", 32'(tick), 0);
    repeat (3) strobe(1);
    chk_timer("c4", 1, 4, 2, 0);
    repeat (4) strobe(1);
    chk_timer("c8", 1, 8, 3, 0);
    strobe(0); chk("div.a", 32'(tick), 0);
    strobe(0); chk("div.b", 32'(tick), 0);
    strobe(0); chk_timer("c9", 1, 9, 0, 4);
    repeat (3) strobe(1);
    chk_timer("c12", 1, 12, 2, 1);

    // Back-to-back slots at ar=2, ph=1
    slot.i_RATE_VALID = 1'b1; slot.i_RATE = 6'h2C;
    cyc();
    slot.i_RATE = 6'h04;
    cyc(); chk_step("r2C", 1, 1, 1);
    slot.i_RATE = 6'h00;
    cyc(); chk_step("r04", 1, 0, 0);
    slot.i_RATE_VALID = 1'b0;
    cyc(); chk_step("r00", 1, 0, 0);
    cyc(); chk_step("idle", 0, 0, 0);

    // ar=0, ph=7
    repeat (3) strobe(1);
    chk_timer("c15", 1, 15, 0, 7);
    send("r63.ph7", 6'd63, 1, 8);

    // Tick coincident with a slot: pre-tick ph=7 gives 1, post-tick would give 2
    slot.i_RATE_VALID = 1'b1; slot.i_RATE = 6'd48; stb = 1'b1; tt = 1'b1;
    cyc();
    slot.i_RATE_VALID = 1'b0; slot.i_RATE = '0; stb = 1'b0; tt = 1'b0;
    chk_timer("c16", 1, 16, 4, 0);
    cyc(); chk_step("coinc", 1, 1, 1);

    // ar=4, ph=0
    send("r63.ph0", 6'd63, 1, 16);
    send("r1C.sum11", 6'h1C, 1, 1);
    send("r18.sum10", 6'h18, 0, 0);

    // ar=0, ph=4
    repeat (9) strobe(1);
    chk_timer("c25", 1, 25, 0, 4);
    send("r48.ph4", 6'd48, 1, 1);
    send("r33.ph4", 6'h33, 1, 2);

    // Async reset with one result out and one slot in flight
    slot.i_RATE_VALID = 1'b1; slot.i_RATE = 6'd63; stb = 1'b1; tt = 1'b1;
    cyc();
    slot.i_RATE = 6'd48; stb = 1'b0; tt = 1'b0;
    cyc();
    slot.i_RATE_VALID = 1'b0; slot.i_RATE = '0;
    chk_step("pre.rst", 1, 1, 16);
    chk_timer("pre.rst", 0, 26, 1, 6);
    #2 rst = 1'b1;
    #1;
    chk_timer("mrst", 0, 0, 0, 0);
    chk_step("mrst", 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    cyc(); chk("post.rst.a", 32'(slot.o_STEP_VALID), 0);
    cyc(); chk("post.rst.b", 32'(slot.o_STEP_VALID), 0);

    // Counter wrap
    stb = 1'b1; tt = 1'b1;
    repeat (32767) cyc();
    stb = 1'b0; tt = 1'b0;
    chk_timer("max", 1, 32767, 0, 7);
    strobe(1);
    chk_timer("wrap", 1, 0, 15, 0);
    send("r2C.ar15", 6'h2C, 1, 1);
    send("r04.ar15", 6'h04, 1, 1);
    cyc(); chk("drain", 32'(slot.o_STEP_VALID), 0);

    // Enable held inactive with live inputs
    slot.i_RATE_VALID = 1'b1; slot.i_RATE = 6'd63; stb = 1'b1; tt = 1'b1;
    cyc();
    chk_timer("pre.frz", 1, 1, 0, 0);
    ncen = 1'b1; slot.i_RATE = 6'd0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk_timer("frz", 1, 1, 0, 0);
      chk("frz.valid", 32'(slot.o_STEP_VALID), 0);
    end
    ncen = 1'b0; slot.i_RATE_VALID = 1'b0; stb = 1'b0; tt = 1'b0;
    cyc();
    chk_timer("thaw", 0, 1, 0, 0);
    chk_step("thaw", 1, 1, 16);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ika_eg_rate_timer.md
Name: ika_eg_rate_timer

Overview:
- Parametrised successor to the envelope attenuation-rate generator.
- Divides the sample strobe, advances a parallel global time counter, and derives an attenuation rate (trailing-zero count) and a 3-bit envelope phase counter.
- Evaluates per-slot 6-bit effective rates and emits a step-enable and step size for each slot, in a pipeline.
- Sits between the timing generator and the envelope level accumulator, and serves any slot count, because slots are presented serially.

Parameters:
CNTW, 15, global time counter width (>=4)
DIV, 3, sample-strobe divider ratio (>=1)
AW, $clog2(CNTW+1), attenuation-rate output width (derived; do not override)

Ports:
i_EMUCLK  input  1  master clock, all state on posedge
i_MRST  input  1  asynchronous active-high reset
i_phi1_NCEN_n  input  1  active-low clock enable; state advances only when low
i_SAMPLE_STB  input  1  one-enable-cycle pulse per sample boundary
i_TEST_TICK  input  1  forces a tick on every strobe (divider bypass)
i_RATE_VALID  input  1  slot rate present this enable cycle
i_RATE  input  6  effective slot rate {hi[5:2], lo[1:0]}
o_TICK  output  1  one-enable-cycle pulse, time counter advanced
o_CNTR  output  CNTW  global time counter
o_ATTEN_RATE  output  AW  trailing-zero count of o_CNTR
o_ENV_CNTR  output  3  (o_CNTR >> (o_ATTEN_RATE+1)) & 7
o_STEP_VALID  output  1  step result valid
o_STEP_EN  output  1  slot steps this sample
o_STEP_SIZE  output  5  step increment

Behaviour:
- Reset (async, i_MRST=1):
  - All outputs are 0.
  - Divider, counter and pipeline are cleared immediately, regardless of enable.
  - Reset mid-operation discards in-flight slot results.
- Divider: counts 0..DIV-1 on each i_SAMPLE_STB.
  - A tick occurs when i_SAMPLE_STB=1 and (divider==DIV-1 or i_TEST_TICK=1).
  - On tick the divider returns to 0. With i_TEST_TICK=1 every strobe ticks and the divider holds 0.
- On tick, at the same enable edge:
  - o_CNTR <= o_CNTR+1, wrapping mod 2^CNTW.
  - o_ATTEN_RATE <= ctz(new value); ctz(0)=CNTW.
  - o_ENV_CNTR <= (new >> (ctz+1)) & 7. Bits beyond CNTW read 0.
  - o_TICK=1 for exactly that one enable cycle.
- Without a tick these outputs hold.
- Slot pipeline: 2-stage.
  - i_RATE_VALID sampled at enable cycle N produces o_STEP_VALID/EN/SIZE at enable cycle N+2.
  - Accepts one slot per enable cycle, back-to-back, with no stall.
  - Stage 1 captures the rate together with o_ATTEN_RATE/o_ENV_CNTR as they are at cycle N. A simultaneous tick at N therefore uses the pre-tick values.
  - o_STEP_VALID=0 → o_STEP_EN=0 and o_STEP_SIZE=0.
- Step rules (hi=i_RATE[5:2], lo=i_RATE[1:0], ph=captured ENV_CNTR, ar=captured ATTEN_RATE):
  - rate==0: EN=0, SIZE=0.
  - hi<=11, rate!=0: EN = (ar+hi >= 11) && (ph < 4+lo); SIZE = EN ? 1 : 0. The sum is computed without truncation (AW+1 bits).
  - hi>=12: EN=1; SIZE = (ph < 4+lo) ? (2 << (hi-12)) : (1 << (hi-12)). Maximum SIZE is 16.
- Enable gating:
  - While i_phi1_NCEN_n=1 no register changes, and pulses (o_TICK, o_STEP_VALID) persist until the next enable cycle.
  - Inputs are ignored when the enable is inactive.

Test Plan:
- Reset then 3 strobes (DIV=3, TEST=0) → one o_TICK after 3rd; o_CNTR=1, ATTEN=0, ENV=0; no tick on strobes 1,2.
- Strobes until o_CNTR=12 → ATTEN=2, ENV=1; at o_CNTR=4 → ATTEN=2, ENV=0; at o_CNTR=8 → ATTEN=3, ENV=0.
- Preload via 32767 ticks with i_TEST_TICK=1, then one more → o_CNTR=0, ATTEN=15, ENV=0; every strobe ticks.
- With ATTEN=2, ENV=1, rate=0x2C (hi11,lo0) → two cycles later VALID=1, EN=1, SIZE=1. Rate=0x04 at the same state → EN=0. Rate=0 → EN=0, SIZE=0.
- Rate=63 (hi15,lo3): ENV=0 → SIZE=16; ENV=7 → SIZE=8. Rate=48 (hi12,lo0), ENV=4 → SIZE=1.
- Tick coincident with i_RATE_VALID uses pre-tick ATTEN/ENV.
- Async reset asserted between pipeline stages → all outputs 0 immediately, and no VALID afterwards.
- Enable held high for 5 cycles mid-stream → outputs frozen.
